// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder.
// The operands travel down a chain of STAGES registers. Each stage resolves one
// BLK-bit group with a fully expanded lookahead carry network. The only carry
// that crosses a stage boundary is the registered carry out of each group, so
// no combinational carry path spans two stages.
// Latency is STAGES cycles from an accepted input to out_valid. The pipeline
// stalls as a whole when the output holds a result the consumer has not taken.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  // Guard the division so that a bad BLK still reaches the elaboration error below.
  localparam int STAGES = (BLK > 0) ? (WIDTH / BLK) : 1;

  // A group size that does not tile the word cannot be pipelined evenly.
  generate
    if (BLK < 1 || (WIDTH % BLK) != 0) begin : g_bad_params
      $error("cla_pipe_adder: WIDTH must be a positive multiple of BLK");
    end
  endgenerate

  // One BLK-bit lookahead group.
  // The result is packed as {carries[BLK:0], sum[BLK-1:0]}, where carries[0]
  // is the group carry-in and carries[BLK] is the group carry-out.
  // Each carry is built as a flat sum of products: c[i+1] = OR over j of
  // (gx[j] & p[j] & ... & p[i]), with gx = {g, cin}. No carry feeds the next
  // carry, so the group is a two-level network rather than a ripple chain.
  function automatic logic [2*BLK:0] cla_group(
    input logic [BLK-1:0] ga,
    input logic [BLK-1:0] gb,
    input logic           gc
  );
    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   gx;
    logic [BLK:0]   c;
    logic [BLK-1:0] sum;
    logic           term;
    g     = ga & gb;
    p     = ga ^ gb;
    gx    = {g, gc};
    c     = '0;
    c[0]  = gc;
    for (int i = 0; i < BLK; i++) begin
      for (int j = 0; j <= i + 1; j++) begin
        term = gx[j];
        for (int m = j; m <= i; m++) begin
          term = term & p[m];
        end
        c[i+1] = c[i+1] | term;
      end
    end
    sum = p ^ c[BLK-1:0];
    return {c, sum};
  endfunction

  // Pipeline registers.
  // Stage k holds a token before group k has been added. Its registers are:
  //   r_a / r_b : the full operands; only the upper slices are still needed
  //   r_s       : the sum slices already resolved by earlier stages
  //   r_c       : the registered carry into group k
  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_s     [STAGES];
  logic             r_c     [STAGES];

  // Output registers.
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_s;
  logic             r_out_cout;
  logic             r_out_ovf;

  logic             w_enable;
  logic [BLK-1:0]   w_grp_sum  [STAGES];
  logic             w_grp_cout [STAGES];
  logic             w_cmsb;
  logic [WIDTH-1:0] w_final_s;

  // Hold everything only when a finished result is waiting on the consumer.
  // Bubbles advance like tokens; the pipeline does not collapse them.
  assign w_enable = !(r_out_valid && !out_ready);
  assign in_ready = w_enable;

  // Per-stage lookahead group. Each stage reads only its own registers.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [2*BLK:0] w_res;
      assign w_res = cla_group(r_a[gi][gi*BLK +: BLK], r_b[gi][gi*BLK +: BLK], r_c[gi]);
      assign w_grp_sum[gi]  = w_res[BLK-1:0];
      assign w_grp_cout[gi] = w_res[2*BLK];
      if (gi == STAGES - 1) begin : g_msb
        // carries[BLK-1] of the top group is the carry into the word's MSB.
        assign w_cmsb = w_res[2*BLK-1];
      end
    end
  endgenerate

  // Merge the top group's sum slice into the slices resolved by earlier stages.
  always_comb begin
    w_final_s = r_s[STAGES-1];
    w_final_s[(STAGES-1)*BLK +: BLK] = w_grp_sum[STAGES-1];
  end

  // Advance the token chain by one stage whenever the pipeline is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_s[k]     <= '0;
        r_c[k]     <= 1'b0;
      end
    end else if (w_enable) begin
      r_valid[0] <= in_valid;
      r_a[0]     <= a;
      r_b[0]     <= b;
      r_c[0]     <= cin;
      r_s[0]     <= '0;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_a[k]     <= r_a[k-1];
        r_b[k]     <= r_b[k-1];
        r_c[k]     <= w_grp_cout[k-1];
        // Copy the resolved slices, then overwrite the slice this stage produced.
        r_s[k]                   <= r_s[k-1];
        r_s[k][(k-1)*BLK +: BLK] <= w_grp_sum[k-1];
      end
    end
  end

  // Capture a finished result. The data registers keep their last value across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_s     <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else if (w_enable) begin
      r_out_valid <= r_valid[STAGES-1];
      if (r_valid[STAGES-1]) begin
        r_out_s    <= w_final_s;
        r_out_cout <= w_grp_cout[STAGES-1];
        r_out_ovf  <= w_grp_cout[STAGES-1] ^ w_cmsb;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign s         = r_out_s;
  assign cout      = r_out_cout;
  assign ovf       = r_out_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder with WIDTH=16 and BLK=4, giving a latency of 4.
// The stimulus side pushes hand-computed expected results into a queue. A
// separate monitor pops from the queue and compares whenever an output
// handshake occurs. Inputs change on the falling edge; sampling happens 1 time
// unit after the falling edge.
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vc;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          t;
    bit          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q[$];
  exp_t e;

  vec_t v1[5];
  vec_t v4[8];
  vec_t vs[6];

  cla_pipe_adder #(.WIDTH(16), .BLK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: retire one expected entry per output handshake.
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output s=%h cout=%b ovf=%b (no result expected)", s, cout, ovf);
      end else begin
        e = q.pop_front();
        if ({cout, ovf, s} !== {e.c, e.o, e.s}) begin
          errors++;
          $display("FAIL result got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                   s, cout, ovf, e.s, e.c, e.o);
        end else begin
          $display("result s=%h cout=%b ovf=%b ok", s, cout, ovf);
        end
        if (e.lat) begin
          checks++;
          if (cyc - e.t != 4) begin
            errors++;
            $display("FAIL latency got %0d want 4 (s=%h)", cyc - e.t, e.s);
          end
        end
      end
    end
  end

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end else begin
      $display("check %s = %h ok", name, got);
    end
  endtask

  // Present one vector, wait for in_ready (bounded), then complete the transfer.
  task automatic send(input vec_t v, input bit push, input bit lat);
    int guard;
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1;
    a = v.va;
    b = v.vb;
    cin = v.vc;
    #1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b want 1 within 50 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      $display("send a=%h b=%h cin=%b at cycle %0d", v.va, v.vb, v.vc, cyc);
      if (push) begin
        x.s = v.es;
        x.c = v.ec;
        x.o = v.eo;
        x.t = cyc;
        x.lat = lat;
        q.push_back(x);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0", q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Watchdog: the run must always terminate on its own.
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int seen;
    v1 = '{'{16'h0006, 16'h0002, 1'b0, 16'h0008, 1'b0, 1'b0},
           '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0},
           '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
           '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
           '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1}};
    v4 = '{'{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0},
           '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0},
           '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0},
           '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1},
           '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1},
           '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0},
           '{16'h00FF, 16'h0F00, 1'b0, 16'h0FFF, 1'b0, 1'b0},
           '{16'hFFFE, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0}};
    vs = '{'{16'h0001, 16'h0100, 1'b0, 16'h0101, 1'b0, 1'b0},
           '{16'h0002, 16'h0200, 1'b0, 16'h0202, 1'b0, 1'b0},
           '{16'h0003, 16'h0300, 1'b1, 16'h0304, 1'b0, 1'b0},
           '{16'h0004, 16'h0400, 1'b0, 16'h0404, 1'b0, 1'b0},
           '{16'h0005, 16'h0500, 1'b1, 16'h0506, 1'b0, 1'b0},
           '{16'h0006, 16'h0600, 1'b0, 16'h0606, 1'b0, 1'b0}};

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check1("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check1("rst_s", {16'd0, s}, 32'd0);
    check1("rst_cout", {31'd0, cout}, 32'd0);
    check1("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check1("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Single adds, carry chains and overflow corners, each with latency checked.
    for (int i = 0; i < 5; i++) send(v1[i], 1'b1, 1'b1);
    idle();
    wait_drain();

    // Eight back-to-back adds: the latency check also proves consecutive output cycles.
    for (int i = 0; i < 8; i++) send(v4[i], 1'b1, 1'b1);
    idle();
    wait_drain();

    // Fill the pipe with the consumer stalled, hold for 3 cycles, then release.
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(vs[i], 1'b1, 1'b0);
        idle();
      end
      begin
        guard = 0;
        @(negedge clk);
        #1;
        while (!out_valid && guard < 20) begin
          @(negedge clk);
          #1;
          guard++;
        end
        for (int k = 0; k < 3; k++) begin
          check1("stall_out_valid", {31'd0, out_valid}, 32'd1);
          check1("stall_in_ready", {31'd0, in_ready}, 32'd0);
          check1("stall_s_frozen", {16'd0, s}, {16'd0, vs[0].es});
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with the pipe full, including a valid held result; nothing may leak out afterwards.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(v4[i], 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check1("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check1("midrst_s", {16'd0, s}, 32'd0);
    check1("midrst_cout", {31'd0, cout}, 32'd0);
    check1("midrst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check1("no_stale_after_rst", seen, 32'd0);
    check1("queue_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
